c17_response_checker: RTL and testbench
=======================================

Name: c17_response_checker

Overview:
- Downstream response stage for the mapped C17 benchmark netlist (outputs 22GAT, 23GAT) in the fault-injection/test flow.
- Consumes one 2-bit response per applied vector from the circuit under test, plus the matching golden (fault-free) response.
- Compacts the circuit-under-test responses into a MISR signature, counts mismatches and records the index of the first failing vector.
- Reports a pass/fail verdict once a programmed number of vectors has been accepted.

Parameters:
- OUT_W, 2, response width (bit0 = 22GAT, bit1 = 23GAT).
- MISR_W, 16, signature register width.
- MISR_POLY, 16'h002D, feedback polynomial taps.
- MISR_SEED, 16'hFFFF, signature value after reset and at each start.
- CNT_W, 16, width of vector count, index and mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE and DONE only).
- num_vec  in  CNT_W  vectors in the run; sampled when start is accepted.
- vec_valid  in  1  dut_resp/gold_resp valid this cycle.
- vec_ready  out  1  checker accepts a response this cycle.
- dut_resp  in  OUT_W  circuit-under-test response.
- gold_resp  in  OUT_W  golden response.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level).
- pass  out  1  in DONE: mismatch_cnt == 0; 0 otherwise.
- mismatch_cnt  out  CNT_W  mismatching vectors, saturating.
- first_fail_valid  out  1  a mismatch has been recorded this run.
- first_fail_idx  out  CNT_W  0-based index of the first mismatching vector.
- signature  out  MISR_W  current MISR value.

Behaviour:
- Reset:
  - Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
  - On reset: state IDLE; vec_ready=0, busy=0, done=0, pass=0.
  - mismatch_cnt=0, first_fail_valid=0, first_fail_idx=0, signature=MISR_SEED.
  - Internal accepted-vector counter vec_idx=0.
  - Reset asserted mid-run aborts immediately; no partial verdict is retained.
- FSM states IDLE, RUN, DONE; all outputs registered.
  - IDLE --start, num_vec!=0--> RUN.
  - IDLE --start, num_vec==0--> DONE with pass=1 and signature=MISR_SEED.
  - RUN --final accept--> DONE.
  - DONE --start--> restart, same rules as IDLE.
  - start in RUN is ignored.
- On start acceptance: latch num_vec; clear vec_idx, mismatch_cnt, first_fail_valid, first_fail_idx; reload signature=MISR_SEED.
- Handshake:
  - vec_ready = 1 exactly while state is RUN.
  - Accept occurs when vec_valid && vec_ready.
  - vec_valid outside RUN is ignored; no side effects.
- Per accept, all updates occur on the same clock edge:
  - MISR: next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? MISR_POLY : 0) ^ zero-extended dut_resp.
  - On dut_resp != gold_resp:
    - mismatch_cnt increments, saturating at all-ones.
    - If first_fail_valid=0: first_fail_idx=vec_idx and first_fail_valid=1.
  - vec_idx increments.
- Final accept:
  - The final accept is the one where vec_idx == latched num_vec-1.
  - done=1 and pass become visible the cycle after the final accept; vec_ready drops in that same cycle.
- Throughput is one vector per cycle; back-to-back valid is allowed; gaps in vec_valid are allowed.
- Statistics hold stable throughout DONE until the next start or reset.

Test Plan:
- Reset: rst_n low, then high -> all outputs 0; signature=16'hFFFF; vec_ready=0.
- Single vector: start, num_vec=1; dut=gold=2'b01 in the first RUN cycle:
  - signature=16'hFFD2.
  - Next cycle: done=1, pass=1, mismatch_cnt=0, vec_ready=0.
- 4 vectors back-to-back; mismatch on indices 1 and 3 (dut=2'b10, gold=2'b00):
  - mismatch_cnt=2, first_fail_valid=1, first_fail_idx=1, pass=0.
- Gapped valid: 3 vectors with vec_valid low 2 cycles between each -> done exactly one cycle after the third accept; counts identical to the gapless run.
- Edge cases:
  - start with num_vec=0 -> DONE next cycle, pass=1, signature=16'hFFFF.
  - start pulsed during RUN -> no restart; counters continue.
- Abort: rst_n low after 2 of 5 vectors -> IDLE, all outputs at reset values; fresh run of 5 completes normally.

Source files
------------

// File: rtl/c17_response_checker.sv
// Response checker for the C17 netlist: MISR compaction, mismatch counting,
// first-fail capture and pass/fail verdict over a programmed vector count.
module c17_response_checker #(
  parameter int unsigned   OUT_W     = 2,
  parameter int unsigned   MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h002D,
  parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF,
  parameter int unsigned   CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [OUT_W-1:0]  dut_resp,
  input  logic [OUT_W-1:0]  gold_resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic              first_fail_valid,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [MISR_W-1:0] signature
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_vec_q, num_vec_d;
  logic [CNT_W-1:0]   vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d;
  logic               ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;
  logic [MISR_W-1:0]  sig_q, sig_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic               accept;
  logic [MISR_W-1:0]  misr_next;

  assign accept = vec_valid && ready_q;

  // One MISR step folding the circuit-under-test response into the signature.
  always_comb begin
    misr_next = {sig_q[MISR_W-2:0], 1'b0}
              ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
              ^ MISR_W'(dut_resp);
  end

  // Next-state, statistics and registered-output computation.
  always_comb begin
    state_d    = state_q;
    num_vec_d  = num_vec_q;
    vec_idx_d  = vec_idx_q;
    mm_cnt_d   = mm_cnt_q;
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;
    sig_d      = sig_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_vec_d  = num_vec;
          vec_idx_d  = '0;
          mm_cnt_d   = '0;
          ff_valid_d = 1'b0;
          ff_idx_d   = '0;
          sig_d      = MISR_SEED;
          state_d    = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          sig_d     = misr_next;
          vec_idx_d = vec_idx_q + CNT_W'(1);
          if (dut_resp != gold_resp) begin
            if (mm_cnt_q != '1) begin
              mm_cnt_d = mm_cnt_q + CNT_W'(1);
            end
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_idx_d   = vec_idx_q;
            end
          end
          if (vec_idx_q == num_vec_q - CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
    pass_d  = (state_d == DONE) && (mm_cnt_d == '0);
  end

  // State and statistics registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      num_vec_q  <= '0;
      vec_idx_q  <= '0;
      mm_cnt_q   <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      sig_q      <= MISR_SEED;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_vec_q  <= num_vec_d;
      vec_idx_q  <= vec_idx_d;
      mm_cnt_q   <= mm_cnt_d;
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
      sig_q      <= sig_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign vec_ready        = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_cnt     = mm_cnt_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign signature        = sig_q;

endmodule

// File: tb/tb_c17_response_checker.sv
// Cycle-by-cycle table of stimulus and hand-computed expected outputs.
module tb_c17_response_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_vec;
  logic        vec_valid;
  logic        vec_ready;
  logic [1:0]  dut_resp;
  logic [1:0]  gold_resp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] mismatch_cnt;
  logic        first_fail_valid;
  logic [15:0] first_fail_idx;
  logic [15:0] signature;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  c17_response_checker dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .num_vec          (num_vec),
    .vec_valid        (vec_valid),
    .vec_ready        (vec_ready),
    .dut_resp         (dut_resp),
    .gold_resp        (gold_resp),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .mismatch_cnt     (mismatch_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx),
    .signature        (signature)
  );

  // Expected flags are {vec_ready, busy, done, pass}.
  typedef struct {
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic        valid;
    logic [1:0]  dresp;
    logic [1:0]  gresp;
    logic [3:0]  e_flags;
    logic [15:0] e_mm;
    logic        e_ffv;
    logic [15:0] e_ffi;
    logic [15:0] e_sig;
  } row_t;

  row_t rows[$];

  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1100;
  localparam logic [3:0] F_PASS = 4'b0011;
  localparam logic [3:0] F_FAIL = 4'b0010;

  task automatic add(input logic r, input logic s, input logic [15:0] n,
                     input logic v, input logic [1:0] d, input logic [1:0] g,
                     input logic [3:0] f, input logic [15:0] mm,
                     input logic ffv, input logic [15:0] ffi,
                     input logic [15:0] sig);
    row_t x;
    x.rst_n = r; x.start = s; x.num_vec = n; x.valid = v;
    x.dresp = d; x.gresp = g; x.e_flags = f; x.e_mm = mm;
    x.e_ffv = ffv; x.e_ffi = ffi; x.e_sig = sig;
    rows.push_back(x);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  task automatic drive_idle();
    start = 1'b0; num_vec = '0; vec_valid = 1'b0;
    dut_resp = '0; gold_resp = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    //   rst s  num  v  dut    gold   flags   mm  ffv ffi  sig
    // Reset and ignored valid in IDLE
    add(0, 0, 0, 0, 2'b00, 2'b00, F_IDLE, 0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 0, 2'b00, 2'b00, F_IDLE, 0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b11, 2'b00, F_IDLE, 0, 0, 0, 16'hFFFF);
    // Single vector, dut=gold=01
    add(1, 1, 1, 0, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b01, 2'b01, F_PASS, 0, 0, 0, 16'hFFD2);
    add(1, 0, 0, 1, 2'b11, 2'b00, F_PASS, 0, 0, 0, 16'hFFD2);
    // Four back-to-back, mismatches at 1 and 3; start during RUN ignored
    add(1, 1, 4, 0, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFD3);
    add(1, 0, 0, 1, 2'b10, 2'b00, F_RUN,  1, 1, 1, 16'hFF89);
    add(1, 1, 9, 1, 2'b00, 2'b00, F_RUN,  1, 1, 1, 16'hFF3F);
    add(1, 0, 0, 1, 2'b10, 2'b00, F_FAIL, 2, 1, 1, 16'hFE51);
    // Three vectors with two-cycle gaps, mismatches at 0 and 2
    add(1, 1, 3, 0, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b10, 2'b00, F_RUN,  1, 1, 0, 16'hFFD1);
    add(1, 0, 0, 0, 2'b11, 2'b00, F_RUN,  1, 1, 0, 16'hFFD1);
    add(1, 0, 0, 0, 2'b11, 2'b00, F_RUN,  1, 1, 0, 16'hFFD1);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_RUN,  1, 1, 0, 16'hFF8F);
    add(1, 0, 0, 0, 2'b00, 2'b00, F_RUN,  1, 1, 0, 16'hFF8F);
    add(1, 0, 0, 0, 2'b00, 2'b00, F_RUN,  1, 1, 0, 16'hFF8F);
    add(1, 0, 0, 1, 2'b10, 2'b01, F_FAIL, 2, 1, 0, 16'hFF31);
    add(1, 0, 0, 1, 2'b00, 2'b11, F_FAIL, 2, 1, 0, 16'hFF31);
    // num_vec = 0 completes immediately with a pass
    add(1, 1, 0, 0, 2'b00, 2'b00, F_PASS, 0, 0, 0, 16'hFFFF);
    // Abort after 2 of 5 vectors
    add(1, 1, 5, 0, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b01, 2'b01, F_RUN,  0, 0, 0, 16'hFFD2);
    add(1, 0, 0, 1, 2'b11, 2'b00, F_RUN,  1, 1, 1, 16'hFF8A);
    add(0, 0, 0, 1, 2'b00, 2'b00, F_IDLE, 0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b01, 2'b00, F_IDLE, 0, 0, 0, 16'hFFFF);
    // Fresh run of five clean vectors
    add(1, 1, 5, 0, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFFF);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFFD3);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFF8B);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFF3B);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_RUN,  0, 0, 0, 16'hFE5B);
    add(1, 0, 0, 1, 2'b00, 2'b00, F_PASS, 0, 0, 0, 16'hFC9B);

    #2;
    for (int i = 0; i < rows.size(); i++) begin
      rst_n     = rows[i].rst_n;
      start     = rows[i].start;
      num_vec   = rows[i].num_vec;
      vec_valid = rows[i].valid;
      dut_resp  = rows[i].dresp;
      gold_resp = rows[i].gresp;
      @(posedge clk);
      #1;
      chk("flags", i, 32'({vec_ready, busy, done, pass}), 32'(rows[i].e_flags));
      chk("mismatch_cnt", i, 32'(mismatch_cnt), 32'(rows[i].e_mm));
      chk("first_fail_valid", i, 32'(first_fail_valid), 32'(rows[i].e_ffv));
      chk("first_fail_idx", i, 32'(first_fail_idx), 32'(rows[i].e_ffi));
      chk("signature", i, 32'(signature), 32'(rows[i].e_sig));
    end

    // Hand-written: two vectors with an irregular gap, bounded wait for done.
    drive_idle();
    start = 1'b1; num_vec = 16'd2;
    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    vec_valid = 1'b1; dut_resp = 2'b11; gold_resp = 2'b11;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    @(posedge clk); #1;
    chk("gap_still_busy", 100, 32'({busy, done}), 32'(2'b10));
    vec_valid = 1'b1; dut_resp = 2'b01; gold_resp = 2'b00;
    @(posedge clk); #1;
    drive_idle();
    begin
      int budget;
      budget = 0;
      while (!done && budget < 10) begin
        @(posedge clk); #1;
        budget++;
      end
      chk("done_latency", 101, 32'(budget), 32'(0));
    end
    chk("gap_pass", 102, 32'(pass), 32'(0));
    chk("gap_mm", 103, 32'(mismatch_cnt), 32'(1));
    chk("gap_ffi", 104, 32'(first_fail_idx), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
